hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the load-use stall logic, placed beside the decode/execute stage boundary of the 5-stage RISC-V pipeline.
- Combines load-use detection with a per-register scoreboard for variable-latency operations (mul/div, multi-cycle loads) issued from E.
- Also handles branch-flush priority.
- Generates StallF, StallD, FlushD and FlushE for the pipeline registers.

Parameters:
REG_AW, 5, register index width; scoreboard has 2**REG_AW entries
LAT_W, 4, width of the latency countdown per entry
ZERO_REG_EXEMPT, 1, when 1, register index 0 never causes a hazard and is never marked pending

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-low
RS1_D  input  REG_AW  source 1 of the instruction in D
RS2_D  input  REG_AW  source 2 of the instruction in D
RD_D  input  REG_AW  destination of the instruction in D (WAW check)
RegWriteD  input  1  instruction in D writes RD_D
RD_E  input  REG_AW  destination of the instruction in E
RegWriteE  input  1  instruction in E writes RD_E
ResultSrcE  input  1  instruction in E is a single-cycle-latency load
PCSrcE  input  1  taken branch/jump resolved in E
mc_issue  input  1  variable-latency op leaves E this cycle
mc_rd  input  REG_AW  its destination
mc_lat  input  LAT_W  cycles until its result is forwardable; 0 = completion-signalled
mc_done  input  1  completion strobe for a mc_lat==0 op
mc_done_rd  input  REG_AW  destination being completed
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register (bubble)
sb_busy  output  1  any scoreboard entry pending

Behaviour:
- Reset (rst low, async): all entries pending=0 and count=0; all outputs 0.
- Scoreboard entry r: pending bit plus count[LAT_W-1:0], registered.
- Set on mc_issue & (mc_rd==r) & !(ZERO_REG_EXEMPT & r==0): pending<=1, count<=mc_lat.
- Each clock with pending & count!=0: count<=count-1; a 1->0 transition clears pending.
- mc_lat==0 entry: stays pending until mc_done & (mc_done_rd==r), then pending<=0.
- Simultaneous set and clear (decrement or done) on the same entry: set wins, new count loaded.
- mc_done to a non-pending entry: ignored.
- match(a,b) = (a==b) & !(ZERO_REG_EXEMPT & a==0).
- lwStall = ResultSrcE & RegWriteE & (match(RS1_D,RD_E) | match(RS2_D,RD_E)).
- mcStall = mc_issue & (match(RS1_D,mc_rd) | match(RS2_D,mc_rd) | RegWriteD & match(RD_D,mc_rd)). This is the same-cycle case before the entry is registered.
- sbStall = pending[RS1_D] | pending[RS2_D] | RegWriteD & pending[RD_D]. The pending[RD_D] term is the WAW check; entry 0 is never pending when exempt.
- hz = lwStall | mcStall | sbStall.
- Branch priority:
  - PCSrcE=1: StallF=0, StallD=0, FlushD=1, FlushE=1, because the D instruction is wrong-path.
  - Else: StallF=StallD=FlushE=hz, FlushD=0.
- Outputs are combinational from inputs and registered state; scoreboard update latency is 1 cycle.
- sb_busy = OR of all pending bits.
- Async reset mid-operation discards all pending entries; no completion is expected afterwards.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle StallD=1.
  - flush_cnt increments each cycle FlushD=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - REG_AW and LAT_W defaults
  - reg_idx_t typedef
  - lat_t typedef
  - the match() function
- One sub-module, hazard_sb_entry, holds one pending bit plus its counter with set/dec/done inputs. It is instantiated 2**REG_AW times via generate.
- Top-level does read-port muxing and priority.

Test Plan:
1. Load-use: ResultSrcE=1, RegWriteE=1, RD_E=5, RS1_D=5 -> StallF=StallD=FlushE=1 in the same cycle. With RD_E=0 and RS1_D=0 -> all 0.
2. Fixed latency: mc_issue, mc_rd=7, mc_lat=3, next cycles RS2_D=7 -> stall in the issue cycle (mcStall) plus 3 following cycles, then released; sb_busy falls with the release.
3. Completion-signalled: mc_issue, mc_rd=9, mc_lat=0, RS1_D=9 -> stall persists 10 cycles. mc_done, mc_done_rd=9 -> stall drops next cycle.
4. WAW plus branch: entry 12 pending, RegWriteD=1, RD_D=12 -> stall. Assert PCSrcE -> StallF=StallD=0, FlushD=FlushE=1.
5. Simultaneous: entry 4 count=1 and mc_issue to 4 with mc_lat=2 in the same cycle -> entry stays pending 2 more cycles. mc_done to idle entry 6 -> no change.
6. Reset mid-op: three entries pending, pulse rst low -> sb_busy=0 immediately, all outputs 0. With HAZARD_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types, default widths and the zero-register-aware index compare for the hazard unit.
package hazard_pkg;

  localparam int unsigned DefRegAw = 5;
  localparam int unsigned DefLatW  = 4;

  typedef logic [DefRegAw-1:0] reg_idx_t;
  typedef logic [DefLatW-1:0]  lat_t;

  // Operands are zero-extended by the caller so any REG_AW up to 32 compares exactly.
  function automatic logic match(input logic [31:0] a, input logic [31:0] b, input logic exempt);
    return (a == b) && !(exempt && (a == 32'd0));
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a pending bit plus a latency countdown (count 0 = wait for done strobe).
module hazard_sb_entry #(
  parameter int unsigned LatW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  logic [LatW-1:0] lat_i,
  input  logic            done_i,
  output logic            pending_o
);

  logic            pending_q, pending_d;
  logic [LatW-1:0] count_q, count_d;

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (set_i) begin
      // A new issue overrides any decrement or completion landing in the same cycle.
      pending_d = 1'b1;
      count_d   = lat_i;
    end else if (pending_q && (count_q != '0)) begin
      count_d = count_q - LatW'(1);
      if (count_q == LatW'(1)) pending_d = 1'b0;
    end else if (pending_q && done_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use, variable-latency scoreboard and branch-flush hazard control for the D/E boundary.
// Optional HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW          = DefRegAw,
  parameter int unsigned LAT_W           = DefLatW,
  parameter int unsigned ZERO_REG_EXEMPT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RD_D,
  input  logic              RegWriteD,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              RegWriteE,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              mc_issue,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [LAT_W-1:0]  mc_lat,
  input  logic              mc_done,
  input  logic [REG_AW-1:0] mc_done_rd,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              sb_busy
);

  localparam int unsigned NumRegs    = 2 ** REG_AW;
  localparam bit          ExemptZero = (ZERO_REG_EXEMPT != 0);

  logic [NumRegs-1:0] pending;

  for (genvar r = 0; r < NumRegs; r++) begin : g_entry
    localparam bit Exempt = ExemptZero && (r == 0);
    logic set, done;
    assign set  = mc_issue && (mc_rd == REG_AW'(r)) && !Exempt;
    assign done = mc_done && (mc_done_rd == REG_AW'(r));

    hazard_sb_entry #(
      .LatW (LAT_W)
    ) u_entry (
      .clk_i     (clk),
      .rst_ni    (rst),
      .set_i     (set),
      .lat_i     (mc_lat),
      .done_i    (done),
      .pending_o (pending[r])
    );
  end

  logic lw_stall, mc_stall, sb_stall, hz;

  always_comb begin
    lw_stall = ResultSrcE && RegWriteE &&
               (match(32'(RS1_D), 32'(RD_E), ExemptZero) ||
                match(32'(RS2_D), 32'(RD_E), ExemptZero));
    // Covers the issue cycle, before the entry has been registered.
    mc_stall = mc_issue &&
               (match(32'(RS1_D), 32'(mc_rd), ExemptZero) ||
                match(32'(RS2_D), 32'(mc_rd), ExemptZero) ||
                (RegWriteD && match(32'(RD_D), 32'(mc_rd), ExemptZero)));
    sb_stall = pending[RS1_D] || pending[RS2_D] || (RegWriteD && pending[RD_D]);
    hz       = lw_stall || mc_stall || sb_stall;

    if (PCSrcE) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = hz;
      StallD = hz;
      FlushD = 1'b0;
      FlushE = hz;
    end
  end

  assign sb_busy = |pending;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
